cmd_arbiter_ctrl: RTL and testbench

CMD_ARBITER_CTRL -- requirements
Module: cmd_arbiter_ctrl

---
 rtl/cmd_arbiter_ctrl.sv | 112 +++++++++++
 tb/tb_cmd_arbiter_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter_ctrl.sv
// cmd_arbiter_ctrl: two-requester GET/PUT/DEL arbiter driving a key/value lookup array.
// Optional round-robin grant via CMD_ARB_ROUND_ROBIN_EN (default: requester 0 priority).
module cmd_arbiter_ctrl #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VAL_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [3:0]             req_op,
    input  logic [2*KEY_WIDTH-1:0] req_key,
    input  logic [2*VAL_WIDTH-1:0] req_val,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [VAL_WIDTH-1:0]   resp_data,
    output logic                   resp_err,
    output logic [KEY_WIDTH-1:0]   mem_key,
    input  logic                   hit,
    input  logic [NUM_ENTRIES-1:0] hit_idx,
    input  logic [NUM_ENTRIES-1:0] used,
    input  logic [VAL_WIDTH-1:0]   mem_rdata,
    output logic [NUM_ENTRIES-1:0] mem_idx,
    output logic                   mem_write,
    output logic                   mem_del,
    output logic [VAL_WIDTH-1:0]   mem_wval
);
    typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
    state_t                 r_state, w_next;
    logic                   r_grant, w_grant, w_accept;
    logic [1:0]             r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VAL_WIDTH-1:0]   r_val;
    logic                   r_hit;
    logic [NUM_ENTRIES-1:0] r_hit_idx, r_used, w_free;
    logic                   w_full, w_get, w_put, w_del, w_err;

    assign w_accept = (r_state == IDLE) && |req_valid;
`ifdef CMD_ARB_ROUND_ROBIN_EN
    logic r_last_grant;
    assign w_grant = &req_valid ? ~r_last_grant : ~req_valid[0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_last_grant <= 1'b1;
        else if (w_accept) r_last_grant <= w_grant;
`else
    assign w_grant = ~req_valid[0];
`endif
    // reset gating keeps req_ready low while rst_n is asserted
    assign req_ready = (w_accept && rst_n) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    // lowest clear bit of the occupancy map
    assign w_free = ~r_used & (r_used + NUM_ENTRIES'(1));
    assign w_full = &r_used;
    assign w_get  = r_op == 2'd0;
    assign w_put  = r_op == 2'd1;
    assign w_del  = r_op == 2'd2;
    assign w_err  = (r_op == 2'd3) || (!r_hit && !(w_put && !w_full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_op      <= '0;
            r_key     <= '0;
            r_val     <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_used    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_grant <= w_grant;
                r_op    <= w_grant ? req_op[3:2] : req_op[1:0];
                r_key   <= w_grant ? req_key[2*KEY_WIDTH-1:KEY_WIDTH] : req_key[KEY_WIDTH-1:0];
                r_val   <= w_grant ? req_val[2*VAL_WIDTH-1:VAL_WIDTH] : req_val[VAL_WIDTH-1:0];
            end
            if (r_state == LOOKUP) begin
                r_hit     <= hit;
                r_hit_idx <= hit_idx;
                r_used    <= used;
            end
            if (r_state == EXEC) begin
                resp_data <= (w_get && r_hit) ? mem_rdata : '0;
                resp_err  <= w_err;
            end
        end
    end

    always_comb begin
        w_next = r_state == IDLE   ? (|req_valid ? LOOKUP : IDLE) :
                 r_state == LOOKUP ? EXEC :
                 r_state == EXEC   ? RESP :
                 (resp_ready[r_grant] ? IDLE : RESP);
        mem_key    = '0;
        mem_idx    = '0;
        mem_write  = 1'b0;
        mem_del    = 1'b0;
        mem_wval   = '0;
        resp_valid = '0;
        if (r_state == LOOKUP) mem_key = r_key;
        if (r_state == EXEC) begin
            mem_write = w_put && (r_hit || !w_full);
            mem_del   = w_del && r_hit;
            mem_idx   = (r_op != 2'd3 && r_hit) ? r_hit_idx : (w_put && !w_full) ? w_free : '0;
            mem_wval  = mem_write ? r_val : '0;
        end
        if (r_state == RESP) resp_valid[r_grant] = 1'b1;
    end
endmodule

// File: tb/tb_cmd_arbiter_ctrl.sv
// tb_cmd_arbiter_ctrl: directed self-checking bench for cmd_arbiter_ctrl.
// Expected grant order depends on CMD_ARB_ROUND_ROBIN_EN.
module tb_cmd_arbiter_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0]  req_op;
    logic [31:0] req_key;
    logic [63:0] req_val;
    logic [31:0] resp_data, mem_rdata, mem_wval;
    logic        resp_err, hit, mem_write, mem_del;
    logic [15:0] mem_key, hit_idx, used, mem_idx;
    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  g_rdy, g_rv;
    logic [15:0] g_mk, g_idx;
    logic        g_lk, g_wr, g_dl;
    logic [31:0] g_wv;
    logic [1:0]  arb_exp [4];

    cmd_arbiter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .req_val(req_val),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .mem_key(mem_key), .hit(hit), .hit_idx(hit_idx),
        .used(used), .mem_rdata(mem_rdata), .mem_idx(mem_idx),
        .mem_write(mem_write), .mem_del(mem_del), .mem_wval(mem_wval)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command and walk IDLE->LOOKUP->EXEC->RESP, sampling each stage.
    task automatic cmd(input int r, input logic [1:0] op, input logic [15:0] key,
                       input logic [31:0] val, input logic h, input logic [15:0] hidx,
                       input logic [15:0] u, input logic [31:0] rd, input logic [1:0] busy_v);
        req_valid = 2'(1 << r);
        req_op = {op, op};
        req_key = {key, key};
        req_val = {val, val};
        hit = h; hit_idx = hidx; used = u; mem_rdata = rd;
        #1;
        g_rdy = req_ready;
        step();
        req_valid = busy_v;
        g_mk = mem_key;
        g_lk = mem_write | mem_del;
        step();
        g_wr = mem_write; g_dl = mem_del; g_idx = mem_idx; g_wv = mem_wval;
        step();
        g_rv = resp_valid;
    endtask

    task automatic handshake(input int r);
        resp_ready = 2'(1 << r);
        step();
        resp_ready = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 0; req_op = 0; req_key = 0; req_val = 0;
        resp_ready = 0; hit = 0; hit_idx = 0; used = 0; mem_rdata = 0;
`ifdef CMD_ARB_ROUND_ROBIN_EN
        arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        step(); step();
        chk("rst_outs", {req_ready, resp_valid, resp_err, mem_write, mem_del}, 0);
        chk("rst_data", {resp_data, mem_wval}, 0);
        chk("rst_mem", {mem_key, mem_idx}, 0);
        rst_n = 1'b1;
        step();

        // PUT new key to empty array
        cmd(0, 2'd1, 16'h0011, 32'hDEADBEEF, 1'b0, 16'h0000, 16'h0000, 32'h0, 2'b00);
        chk("put_ready", g_rdy, 2'b01);
        chk("put_memkey", g_mk, 16'h0011);
        chk("put_lookup_strobe", g_lk, 0);
        chk("put_write", {g_wr, g_dl}, 2'b10);
        chk("put_idx", g_idx, 16'h0001);
        chk("put_wval", g_wv, 32'hDEADBEEF);
        chk("put_resp", {g_rv, resp_err}, 3'b010);
        handshake(0);
        chk("put_done", resp_valid, 2'b00);

        // GET hit from requester 1, response held under backpressure and wrong-bit ready
        cmd(1, 2'd0, 16'h0011, 32'h0, 1'b1, 16'h0004, 16'h0005, 32'hDEADBEEF, 2'b01);
        chk("get_ready", g_rdy, 2'b10);
        chk("get_strobes", {g_wr, g_dl}, 2'b00);
        chk("get_idx", g_idx, 16'h0004);
        chk("get_resp", {g_rv, resp_err}, 3'b100);
        chk("get_data", resp_data, 32'hDEADBEEF);
        resp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("get_hold_valid", resp_valid, 2'b10);
            chk("get_hold_data", {resp_data, resp_err}, {32'hDEADBEEF, 1'b0});
            chk("busy_ready", req_ready, 2'b00);
        end
        resp_ready = 2'b10;
        step();
        resp_ready = 2'b00;
        #1;
        chk("get_done", resp_valid, 2'b00);
        chk("next_accept", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        // PUT miss with array full
        cmd(0, 2'd1, 16'h0022, 32'h12345678, 1'b0, 16'h0000, 16'hFFFF, 32'h0, 2'b00);
        chk("full_strobes", {g_wr, g_dl}, 2'b00);
        chk("full_resp", {g_rv, resp_err}, 3'b011);
        handshake(0);

        // DEL miss
        cmd(0, 2'd2, 16'h0033, 32'h0, 1'b0, 16'h0000, 16'h0001, 32'hCAFEF00D, 2'b00);
        chk("delmiss_strobes", {g_wr, g_dl}, 2'b00);
        chk("delmiss_resp", {g_rv, resp_err}, 3'b011);
        chk("delmiss_data", resp_data, 0);
        handshake(0);

        // DEL hit at top slot
        cmd(1, 2'd2, 16'h0044, 32'h0, 1'b1, 16'h8000, 16'h8001, 32'h0, 2'b00);
        chk("delhit_strobes", {g_wr, g_dl}, 2'b01);
        chk("delhit_idx", g_idx, 16'h8000);
        chk("delhit_resp", {g_rv, resp_err}, 3'b100);
        handshake(1);

        // Reserved op
        cmd(0, 2'd3, 16'h0011, 32'h1, 1'b1, 16'h0004, 16'h0005, 32'h0, 2'b00);
        chk("op3_strobes", {g_wr, g_dl}, 2'b00);
        chk("op3_resp", {g_rv, resp_err}, 3'b011);
        handshake(0);

        // Reset during EXEC of a PUT
        req_valid = 2'b10; req_op = 4'b0101; hit = 0; used = 0;
        #1;
        chk("rx_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        chk("rx_exec_write", mem_write, 1'b1);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rx_abort_strobes", {mem_write, mem_del, mem_idx, mem_wval}, 0);
        chk("rx_abort_outs", {req_ready, resp_valid, resp_err, resp_data, mem_key}, 0);
        step(); step();
        chk("rx_hold", {mem_write, mem_del, req_ready, resp_valid}, 0);
        rst_n = 1'b1;

        // Both requesters valid continuously for four GETs
        req_op = 4'b0000; hit = 0; resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8 && req_ready == 2'b00; t++) step();
            chk($sformatf("arb_grant%0d", k), req_ready, arb_exp[k]);
            step();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
